// File: rtl/ls_queue.sv
// ---------------------------------------------------------------------------
// ls_queue
//
// Load/store request queue between the execute stage and a data cache.
// Requests are buffered in a circular FIFO and sent to the cache one at a
// time, in order. Each request completes with a one-cycle write-back pulse
// that carries the producer's tag. For loads, the pulse also carries the
// extended load value.
//
// Optional feature (macro LS_QUEUE_SIGN_EXT_EN):
//   When defined, a load with req_unsigned=0 is sign-extended from bit
//   8*size-1. When undefined, all loads are zero-extended and req_unsigned
//   is neither used nor stored.
//
// Ports:
//   clk, rst             clock (rising edge), asynchronous active-low reset
//   rdy                  global enable; when low, every register holds
//   req_valid/req_ready  request handshake; req_ready is high while not full
//   req_oper             0 = load, 1 = store
//   req_addr, req_data   byte address, store data
//   req_size             byte count (1, 2 or 4)
//   req_unsigned         load zero-extend select
//   req_tag              tag returned with the completion
//   flush                discard all pending work
//   en_ls, ls_oper, ls_addr, ls_data, ls_size   cache request port
//   in_fifo              cache accept pulse
//   finish, ls_data_out  cache load-data-valid pulse and load data
//   wb_valid, wb_tag, wb_data                   completion port
// ---------------------------------------------------------------------------
module ls_queue #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_oper,
  input  logic [31:0]      req_addr,
  input  logic [31:0]      req_data,
  input  logic [7:0]       req_size,
  input  logic             req_unsigned,
  input  logic [TAG_W-1:0] req_tag,
  input  logic             flush,
  output logic             en_ls,
  output logic             ls_oper,
  output logic [31:0]      ls_addr,
  output logic [31:0]      ls_data,
  output logic [7:0]       ls_size,
  input  logic             in_fifo,
  input  logic             finish,
  input  logic [31:0]      ls_data_out,
  output logic             wb_valid,
  output logic [TAG_W-1:0] wb_tag,
  output logic [31:0]      wb_data
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, ACK, WAIT_LD} state_t;

  state_t state, state_next;

  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [IDX_W-1:0] wr_idx, rd_idx;
  logic             full, empty, push;

  logic             q_oper [DEPTH];
  logic [31:0]      q_addr [DEPTH];
  logic [31:0]      q_data [DEPTH];
  logic [7:0]       q_size [DEPTH];
  logic [TAG_W-1:0] q_tag  [DEPTH];

  logic [TAG_W-1:0] cur_tag;
  logic             suppress;
  logic             load_sext;

  logic issue, reissue, pop, wb_store, wb_load;

  // The pointers carry one extra wrap bit, so "full" and "empty" can be
  // told apart even when the index bits are equal.
  assign wr_idx    = wr_ptr[IDX_W-1:0];
  assign rd_idx    = rd_ptr[IDX_W-1:0];
  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[PTR_W-1] != rd_ptr[PTR_W-1]) && (wr_idx == rd_idx);
  assign req_ready = ~full;
  assign push      = rdy & req_valid & ~full & ~flush;

`ifdef LS_QUEUE_SIGN_EXT_EN
  logic q_uns [DEPTH];
  logic cur_unsigned;

  // Keep the extend mode with each entry. Latch it again when the entry
  // is issued, because the entry is popped before its load data returns.
  always_ff @(posedge clk) begin
    if (rdy && push) q_uns[wr_idx] <= req_unsigned;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                cur_unsigned <= 1'b0;
    else if (rdy && issue)   cur_unsigned <= q_uns[rd_idx];
  end

  assign load_sext = ~cur_unsigned;
`else
  logic unused_req_unsigned;
  assign unused_req_unsigned = req_unsigned;
  assign load_sext = 1'b0;
`endif

  // Trim the raw cache word to the access size, then fill the upper bits
  // with zeros or with the access's sign bit.
  function automatic logic [31:0] extend_load(input logic [31:0] raw,
                                              input logic [7:0]  size,
                                              input logic        sext);
    logic [31:0] res;
    case (size)
      8'd1:    res = {{24{sext & raw[7]}}, raw[7:0]};
      8'd2:    res = {{16{sext & raw[15]}}, raw[15:0]};
      default: res = raw;
    endcase
    return res;
  endfunction

  // FIFO storage. No reset is needed: only entries between the pointers
  // are ever read.
  always_ff @(posedge clk) begin
    if (rdy && push) begin
      q_oper[wr_idx] <= req_oper;
      q_addr[wr_idx] <= req_addr;
      q_data[wr_idx] <= req_data;
      q_size[wr_idx] <= req_size;
      q_tag[wr_idx]  <= req_tag;
    end
  end

  // Pointer update. A flush empties the queue and drops any push in the
  // same cycle. A push and a pop in the same cycle both take effect.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (rdy) begin
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      end
    end
  end

  // State register for the issue sequencer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)     state <= IDLE;
    else if (rdy) state <= state_next;
  end

  // Next-state logic and per-cycle strobes. Each state reacts only to the
  // cache pulse it expects, so a stray in_fifo or finish is ignored.
  always_comb begin
    state_next = state;
    issue      = 1'b0;
    reissue    = 1'b0;
    pop        = 1'b0;
    wb_store   = 1'b0;
    wb_load    = 1'b0;
    case (state)
      IDLE: begin
        if (!flush && !empty) begin
          state_next = ISSUE;
          issue      = 1'b1;
        end
      end
      ISSUE: begin
        state_next = flush ? IDLE : ACK;
      end
      ACK: begin
        if (flush) begin
          state_next = IDLE;
        end else if (in_fifo) begin
          pop        = 1'b1;
          wb_store   = ls_oper;
          state_next = ls_oper ? IDLE : WAIT_LD;
        end else begin
          state_next = ISSUE;
          reissue    = 1'b1;
        end
      end
      WAIT_LD: begin
        if (finish) begin
          state_next = IDLE;
          wb_load    = ~suppress & ~flush;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Registered cache-request and completion outputs. The head entry is
  // latched on issue and held through retries and the load wait. A load
  // already in flight when a flush arrives is drained silently: the
  // suppress flag mutes its completion.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      en_ls    <= 1'b0;
      ls_oper  <= 1'b0;
      ls_addr  <= '0;
      ls_data  <= '0;
      ls_size  <= '0;
      cur_tag  <= '0;
      wb_valid <= 1'b0;
      wb_tag   <= '0;
      wb_data  <= '0;
      suppress <= 1'b0;
    end else if (rdy) begin
      en_ls    <= issue | reissue;
      wb_valid <= wb_store | wb_load;
      if (issue) begin
        ls_oper <= q_oper[rd_idx];
        ls_addr <= q_addr[rd_idx];
        ls_data <= q_data[rd_idx];
        ls_size <= q_size[rd_idx];
        cur_tag <= q_tag[rd_idx];
      end
      if (wb_store) begin
        wb_tag  <= cur_tag;
        wb_data <= '0;
      end else if (wb_load) begin
        wb_tag  <= cur_tag;
        wb_data <= extend_load(ls_data_out, ls_size, load_sext);
      end
      if (state == WAIT_LD && finish)      suppress <= 1'b0;
      else if (state == WAIT_LD && flush)  suppress <= 1'b1;
    end
  end

endmodule
